// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// State encoding, register-zero index and ID/EX control field widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    FREEZE  = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int WB_W = 2;
  localparam int M_W  = 3;
  localparam int EX_W = 4;

  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [M_W-1:0]  m;
    logic [EX_W-1:0] ex;
  } idex_ctl_t;

  localparam idex_ctl_t CTL_BUBBLE = '0;

endpackage

// File: rtl/pipe_hazard_ctl_sat_counter.sv
// Saturating up-counter used for the stall and flush statistics.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Hazard and stall controller for the 5-stage pipeline.
// Mealy enables from state and inputs; load-use, branch flush, mem freeze.
module pipe_hazard_ctl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_we,
  output logic             pc_sel_br,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_bubble,
  output logic             exmem_we,
  output logic             exmem_flush,
  output logic             memwb_we,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(MEM_TIMEOUT);

  hz_state_t state, state_n;
  logic lu, lu_act, flush_inc;
  logic [TW-1:0] tmo, tmo_n;

  assign lu = idex_memread
           && (idex_rt != REG_ZERO)
           && ((idex_rt == ifid_rs)
            || (ifid_uses_rt && (idex_rt == ifid_rt)));

  // The load already sits in EX/MEM during LDSTALL; forwarding covers it.
  assign lu_act = lu && (state != LDSTALL);

  always_ff @(posedge clk) begin
    if (rst)
      state <= RUN;
    else
      state <= state_n;
  end

  always_comb begin
    pc_we       = 1'b1;
    pc_sel_br   = 1'b0;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_we     = 1'b1;
    idex_bubble = 1'b0;
    exmem_we    = 1'b1;
    exmem_flush = 1'b0;
    memwb_we    = 1'b1;
    flush_inc   = 1'b0;
    state_n     = RUN;
    priority case (1'b1)
      rst: begin
        state_n = RUN;
      end
      mem_busy: begin
        pc_we    = 1'b0;
        ifid_we  = 1'b0;
        idex_we  = 1'b0;
        exmem_we = 1'b0;
        memwb_we = 1'b0;
        state_n  = FREEZE;
      end
      branch_taken: begin
        pc_sel_br   = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        exmem_flush = 1'b1;
        flush_inc   = 1'b1;
      end
      lu_act: begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_bubble = 1'b1;
        state_n     = LDSTALL;
      end
      default: begin
        state_n = RUN;
      end
    endcase
  end

  always_comb begin
    tmo_n = '0;
    if (mem_busy)
      tmo_n = (tmo == TMAX) ? tmo : tmo + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo     <= '0;
      mem_err <= 1'b0;
    end else begin
      tmo     <= tmo_n;
      mem_err <= mem_err | (tmo_n == TMAX);
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (~pc_we),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .cnt (flush_cnt)
  );

endmodule
